// File: rtl/ram_copy_engine.sv
`default_nettype none
// ============================================================================
// Module   : ram_copy_engine
// Purpose  : DMA-style initiator on the single-port word RAM. Performs a
//            word-granular block copy (read source, write destination) or a
//            block fill with a constant, ascending or descending.
// Revision : 1.0 - initial release
// ============================================================================
module ram_copy_engine #(
    parameter int LEN_W = 11
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             fill_i,
    input  logic             descend_i,
    input  logic [31:0]      src_i,
    input  logic [31:0]      dst_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [31:0]      fill_value_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [31:0]      addr_o,
    output logic [31:0]      write_data_o,
    output logic [3:0]       write_mask_o,
    input  logic [31:0]      read_data_i
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_FILL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [31:0]      C_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0]      C_STEP_UP    = 32'h0000_0004;
    localparam logic [31:0]      C_STEP_DOWN  = 32'hFFFF_FFFC;
    localparam logic [LEN_W-1:0] C_ONE        = LEN_W'(1);

    state_t             r_state;
    logic [31:0]        r_src;
    logic [31:0]        r_dst;
    logic [LEN_W-1:0]   r_count;
    logic [31:0]        r_fill_value;
    logic               r_descend;
    logic [31:0]        r_addr;
    logic [3:0]         r_mask;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_next;
    logic [31:0]        w_src_next;
    logic [31:0]        w_dst_next;
    logic [LEN_W-1:0]   w_count_next;
    logic [31:0]        w_fill_value_next;
    logic               w_descend_next;
    logic [31:0]        w_addr_next;
    logic [3:0]         w_mask_next;
    logic [31:0]        w_step;
    logic               w_last;

    assign w_step = r_descend ? C_STEP_DOWN : C_STEP_UP;
    assign w_last = (r_count == C_ONE);

    // Next-state, pointer/count update, and next values of the registered outputs
    always_comb begin
        w_state_next      = r_state;
        w_src_next        = r_src;
        w_dst_next        = r_dst;
        w_count_next      = r_count;
        w_fill_value_next = r_fill_value;
        w_descend_next    = r_descend;

        if (abort_i) begin
            // Abort takes priority over everything, including a start in IDLE
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        w_src_next        = src_i & C_ALIGN_MASK;
                        w_dst_next        = dst_i & C_ALIGN_MASK;
                        w_count_next      = len_i;
                        w_fill_value_next = fill_value_i;
                        w_descend_next    = descend_i;
                        if (len_i == '0) begin
                            w_state_next = S_DONE;
                        end else if (fill_i) begin
                            w_state_next = S_FILL;
                        end else begin
                            w_state_next = S_READ;
                        end
                    end
                end
                S_READ: begin
                    w_state_next = S_WRITE;
                end
                S_WRITE: begin
                    w_src_next   = r_src + w_step;
                    w_dst_next   = r_dst + w_step;
                    w_count_next = r_count - C_ONE;
                    w_state_next = w_last ? S_DONE : S_READ;
                end
                S_FILL: begin
                    w_dst_next   = r_dst + w_step;
                    w_count_next = r_count - C_ONE;
                    w_state_next = w_last ? S_DONE : S_FILL;
                end
                S_DONE: begin
                    w_state_next = S_IDLE;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end

        // Outputs are registered, so they are derived from the state being entered
        w_addr_next = 32'h0;
        w_mask_next = 4'h0;
        case (w_state_next)
            S_READ: begin
                w_addr_next = w_src_next;
            end
            S_WRITE, S_FILL: begin
                w_addr_next = w_dst_next;
                w_mask_next = 4'hF;
            end
            default: begin
                w_addr_next = 32'h0;
                w_mask_next = 4'h0;
            end
        endcase
    end

    // State, transfer context and registered outputs
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state      <= S_IDLE;
            r_src        <= 32'h0;
            r_dst        <= 32'h0;
            r_count      <= '0;
            r_fill_value <= 32'h0;
            r_descend    <= 1'b0;
            r_addr       <= 32'h0;
            r_mask       <= 4'h0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_src        <= w_src_next;
            r_dst        <= w_dst_next;
            r_count      <= w_count_next;
            r_fill_value <= w_fill_value_next;
            r_descend    <= w_descend_next;
            r_addr       <= w_addr_next;
            r_mask       <= w_mask_next;
            r_busy       <= (w_state_next != S_IDLE);
            r_done       <= (w_state_next == S_DONE);
        end
    end

    // Write data: RAM read data passes straight through in WRITE (1-cycle read latency)
    always_comb begin
        write_data_o = 32'h0;
        case (r_state)
            S_WRITE: write_data_o = read_data_i;
            S_FILL:  write_data_o = r_fill_value;
            default: write_data_o = 32'h0;
        endcase
    end

    assign addr_o       = r_addr;
    assign write_mask_o = r_mask;
    assign busy_o       = r_busy;
    assign done_o       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_copy_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_copy_engine
// Purpose  : Self-checking bench for ram_copy_engine with a behavioural
//            single-port RAM (1-cycle registered read).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_copy_engine;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        start_i;
    logic        abort_i;
    logic        fill_i;
    logic        descend_i;
    logic [31:0] src_i;
    logic [31:0] dst_i;
    logic [10:0] len_i;
    logic [31:0] fill_value_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] addr_o;
    logic [31:0] write_data_o;
    logic [3:0]  write_mask_o;
    logic [31:0] read_data_i;

    logic        clr_req;
    logic [31:0] mem [1024];

    int n_checks = 0;
    int n_fail   = 0;

    ram_copy_engine #(.LEN_W(11)) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .fill_i       (fill_i),
        .descend_i    (descend_i),
        .src_i        (src_i),
        .dst_i        (dst_i),
        .len_i        (len_i),
        .fill_value_i (fill_value_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .addr_o       (addr_o),
        .write_data_o (write_data_o),
        .write_mask_o (write_mask_o),
        .read_data_i  (read_data_i)
    );

    always #5 clk_i = ~clk_i;

    // RAM model; clr_req reloads the pattern 1,2,3,4 at words 0..3, zero elsewhere
    always @(posedge clk_i) begin
        if (clr_req) begin
            for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
            mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd4;
        end else if (write_mask_o == 4'hF) begin
            mem[addr_o[11:2]] = write_data_o;
        end
        read_data_i <= mem[addr_o[11:2]];
    end

    typedef struct {
        string       name;
        logic        fill;
        logic        desc;
        logic [31:0] src;
        logic [31:0] dst;
        logic [10:0] len;
        logic [31:0] val;
        int          exp_lat;
        logic [31:0] chk_addr;
        logic [3:0][31:0] exp;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk(input string name, input logic fill, input logic desc,
                                input logic [31:0] src, input logic [31:0] dst,
                                input logic [10:0] len, input logic [31:0] val,
                                input int lat, input logic [31:0] chk,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3);
        vec_t v;
        v.name = name; v.fill = fill; v.desc = desc; v.src = src; v.dst = dst;
        v.len = len; v.val = val; v.exp_lat = lat; v.chk_addr = chk;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        @(negedge clk_i);
        clr_req = 1'b1;
        @(negedge clk_i);
        clr_req = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat, busy_n, wr_n, done_n, misal;
        clear_mem();
        fill_i = v.fill; descend_i = v.desc; src_i = v.src; dst_i = v.dst;
        len_i = v.len; fill_value_i = v.val; start_i = 1'b1;
        lat = 0; busy_n = 0; wr_n = 0; done_n = 0; misal = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (busy_o) busy_n++;
            if (write_mask_o != 4'h0) begin
                wr_n++;
                if (addr_o[1:0] != 2'b00) misal++;
            end
            if (done_o) begin
                done_n++;
                if (lat == 0) lat = k;
            end
        end
        check({v.name, " done latency"}, lat, v.exp_lat);
        check({v.name, " busy cycles"}, busy_n, v.exp_lat);
        check({v.name, " write cycles"}, wr_n, 32'(v.len));
        check({v.name, " done pulses"}, done_n, 1);
        check({v.name, " misaligned writes"}, misal, 0);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s mem[%h]", v.name, v.chk_addr + 32'(4 * i)),
                  mem[(v.chk_addr[11:2]) + 10'(i)], v.exp[i]);
    endtask

    task automatic check_all_zero(input string name);
        check({name, " busy"}, busy_o, 0);
        check({name, " done"}, done_o, 0);
        check({name, " addr"}, addr_o, 0);
        check({name, " wdata"}, write_data_o, 0);
        check({name, " mask"}, write_mask_o, 0);
    endtask

    initial begin
        int cnt_done, cnt_mask;
        reset_ni = 1'b1; start_i = 1'b0; abort_i = 1'b0; fill_i = 1'b0;
        descend_i = 1'b0; src_i = 32'h0; dst_i = 32'h0; len_i = '0;
        fill_value_i = 32'h0; clr_req = 1'b0;

        vecs[0] = mk("fill4",   1, 0, 32'h0, 32'h100, 11'd4, 32'hDEADBEEF, 5, 32'h100,
                     32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        vecs[1] = mk("copy4",   0, 0, 32'h0, 32'h200, 11'd4, 32'h0, 9, 32'h200, 1, 2, 3, 4);
        vecs[2] = mk("ovl_desc", 0, 1, 32'h8, 32'hC, 11'd3, 32'h0, 7, 32'h0, 1, 1, 2, 3);
        vecs[3] = mk("len0",    0, 0, 32'h0, 32'h300, 11'd0, 32'h0, 1, 32'h300, 0, 0, 0, 0);
        vecs[4] = mk("fill_desc", 1, 1, 32'h0, 32'h10C, 11'd3, 32'hA5A5A5A5, 4, 32'h100,
                     32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
        vecs[5] = mk("ovl_asc", 0, 0, 32'h4, 32'h0, 11'd3, 32'h0, 7, 32'h0, 2, 3, 4, 4);
        vecs[6] = mk("unaligned", 0, 0, 32'h3, 32'h205, 11'd2, 32'h0, 5, 32'h200, 0, 1, 2, 0);
        vecs[7] = mk("wrap",    1, 0, 32'h0, 32'hFFFFFFFC, 11'd2, 32'h5A5A0001, 3, 32'h0,
                     32'h5A5A0001, 2, 3, 4);

        // Asynchronous reset before any clock edge
        #1 reset_ni = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Abort during the third word of an 8-word fill; a start while busy is ignored
        clear_mem();
        fill_i = 1'b1; descend_i = 1'b0; dst_i = 32'h100; len_i = 11'd8;
        fill_value_i = 32'h11111111; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check("abort k1 addr", addr_o, 32'h100);
        check("abort k1 mask", write_mask_o, 4'hF);
        @(negedge clk_i);
        dst_i = 32'h300; len_i = 11'd1; fill_value_i = 32'h22222222; start_i = 1'b1;
        check("abort k2 addr", addr_o, 32'h104);
        @(negedge clk_i);
        start_i = 1'b0;
        check("abort k3 addr", addr_o, 32'h108);
        check("abort k3 wdata", write_data_o, 32'h11111111);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        check("abort next mask", write_mask_o, 4'h0);
        check("abort next busy", busy_o, 0);
        cnt_done = 0; cnt_mask = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (done_o) cnt_done++;
            if (write_mask_o != 4'h0) cnt_mask++;
        end
        check("abort no done", cnt_done, 0);
        check("abort no further writes", cnt_mask, 0);
        check("abort mem 0x100", mem[64], 32'h11111111);
        check("abort mem 0x104", mem[65], 32'h11111111);
        check("abort mem 0x108", mem[66], 32'h11111111);
        check("abort mem 0x10C", mem[67], 32'h0);
        check("abort mem 0x300", mem[192], 32'h0);

        // Abort and start together in IDLE: start is dropped
        fill_i = 1'b1; dst_i = 32'h100; len_i = 11'd2; start_i = 1'b1; abort_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0; abort_i = 1'b0;
        cnt_mask = 0;
        if (busy_o) cnt_mask++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            if (busy_o || write_mask_o != 4'h0 || done_o) cnt_mask++;
        end
        check("abort+start dropped", cnt_mask, 0);

        // Reset asserted mid-copy, off the clock edge
        clear_mem();
        fill_i = 1'b0; descend_i = 1'b0; src_i = 32'h0; dst_i = 32'h200;
        len_i = 11'd4; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("midcopy busy before reset", busy_o, 1);
        #2 reset_ni = 1'b0;
        #1 check_all_zero("midcopy reset");
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(negedge clk_i);
        check_all_zero("post reset idle");
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
